// File: rtl/xadac_pkg.sv
// Shared widths, AXI response/burst encodings and the initiator FSM state type
// for the xadac vector accelerator's AXI link.
package xadac_pkg;

    localparam int AddrWidth    = 32;
    localparam int VecDataWidth = 128;
    localparam int IdWidth      = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RESP    = 3'd5
    } axi_master_state_e;

endpackage

// File: rtl/xadac_axi_master_if.sv
// AXI4 single-beat bus between the xadac initiator and its subordinate
// (dcache_axi_adapter).
interface xadac_axi_master_if #(
    parameter int AddrWidth = xadac_pkg::AddrWidth,
    parameter int DataWidth = xadac_pkg::VecDataWidth,
    parameter int IdWidth   = xadac_pkg::IdWidth
);
    logic                   aw_valid;
    logic                   aw_ready;
    logic [AddrWidth-1:0]   aw_addr;
    logic [2:0]             aw_size;
    logic [7:0]             aw_len;
    logic [1:0]             aw_burst;
    logic [IdWidth-1:0]     aw_id;
    logic                   w_valid;
    logic                   w_ready;
    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   w_last;
    logic                   b_valid;
    logic                   b_ready;
    logic [1:0]             b_resp;
    logic                   ar_valid;
    logic                   ar_ready;
    logic [AddrWidth-1:0]   ar_addr;
    logic [2:0]             ar_size;
    logic [7:0]             ar_len;
    logic [1:0]             ar_burst;
    logic [IdWidth-1:0]     ar_id;
    logic                   r_valid;
    logic                   r_ready;
    logic [DataWidth-1:0]   r_data;
    logic [1:0]             r_resp;
    logic                   r_last;

    modport master (
        output aw_valid, aw_addr, aw_size, aw_len, aw_burst, aw_id,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_size, ar_len, ar_burst, ar_id,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_size, aw_len, aw_burst, aw_id,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_size, ar_len, ar_burst, ar_id,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready
    );

endinterface

// File: rtl/xadac_axi_master.sv
// One vector load/store request in, one single-beat AXI4 transaction out, one
// response back. At most one transaction outstanding.
module xadac_axi_master #(
    parameter int AddrWidth = xadac_pkg::AddrWidth,
    parameter int DataWidth = xadac_pkg::VecDataWidth,
    parameter int IdWidth   = xadac_pkg::IdWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [2:0]             aw_size_o,
    output logic [7:0]             aw_len_o,
    output logic [1:0]             aw_burst_o,
    output logic [IdWidth-1:0]     aw_id_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic [1:0]             b_resp_i,
    output logic                   ar_valid_o,
    input  logic                   ar_ready_i,
    output logic [AddrWidth-1:0]   ar_addr_o,
    output logic [2:0]             ar_size_o,
    output logic [7:0]             ar_len_o,
    output logic [1:0]             ar_burst_o,
    output logic [IdWidth-1:0]     ar_id_o,
    input  logic                   r_valid_i,
    output logic                   r_ready_o,
    input  logic [DataWidth-1:0]   r_data_i,
    input  logic [1:0]             r_resp_i,
    input  logic                   r_last_i
);
    import xadac_pkg::*;

    localparam logic [2:0]           BeatSize   = 3'($clog2(DataWidth/8));
    localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(DataWidth/8 - 1);

    axi_master_state_e      r_state;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic [DataWidth/8-1:0] r_strb;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_err;
    logic                   r_aw_valid;
    logic                   r_w_valid;

    logic w_misaligned;
    logic w_aw_done;
    logic w_w_done;

    assign w_misaligned = (req_addr_i & OffsetMask) != '0;
    // A channel counts as done if it already handshook or handshakes this cycle.
    assign w_aw_done    = !r_aw_valid || aw_ready_i;
    assign w_w_done     = !r_w_valid  || w_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid_i) begin
                    r_addr  <= req_addr_i;
                    r_wdata <= req_wdata_i;
                    r_strb  <= req_strb_i;
                    r_rdata <= '0;
                    r_err   <= w_misaligned;
                    if (w_misaligned) begin
                        r_state <= RESP;
                    end else if (req_we_i) begin
                        r_state    <= WR_REQ;
                        r_aw_valid <= 1'b1;
                        r_w_valid  <= 1'b1;
                    end else begin
                        r_state <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (r_aw_valid && aw_ready_i) r_aw_valid <= 1'b0;
                    if (r_w_valid && w_ready_i)   r_w_valid  <= 1'b0;
                    if (w_aw_done && w_w_done)    r_state    <= WR_RESP;
                end
                WR_RESP: if (b_valid_i) begin
                    // EXOKAY is an error too: this initiator never issues exclusives.
                    r_err   <= (b_resp_i != RESP_OKAY);
                    r_state <= RESP;
                end
                RD_REQ: if (ar_ready_i) r_state <= RD_RESP;
                RD_RESP: if (r_valid_i) begin
                    r_rdata <= r_data_i;
                    r_err   <= (r_resp_i != RESP_OKAY) || !r_last_i;
                    r_state <= RESP;
                end
                RESP: if (rsp_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = rst_ni && (r_state == IDLE);
    assign rsp_valid_o = (r_state == RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

    // Fixed AXI fields read as zero whenever their channel is idle.
    assign aw_valid_o  = r_aw_valid;
    assign aw_addr_o   = r_addr;
    assign aw_size_o   = r_aw_valid ? BeatSize : 3'd0;
    assign aw_len_o    = 8'd0;
    assign aw_burst_o  = r_aw_valid ? BURST_INCR : 2'b00;
    assign aw_id_o     = '0;

    assign w_valid_o   = r_w_valid;
    assign w_data_o    = r_wdata;
    assign w_strb_o    = r_strb;
    assign w_last_o    = r_w_valid;

    assign b_ready_o   = (r_state == WR_RESP);

    assign ar_valid_o  = (r_state == RD_REQ);
    assign ar_addr_o   = r_addr;
    assign ar_size_o   = ar_valid_o ? BeatSize : 3'd0;
    assign ar_len_o    = 8'd0;
    assign ar_burst_o  = ar_valid_o ? BURST_INCR : 2'b00;
    assign ar_id_o     = '0;

    assign r_ready_o   = (r_state == RD_RESP);

endmodule
